// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - machine-mode trap entry/exit sequencer driving the CSR write port
module trap_sequencer #(
  parameter logic [31:0] ECALL_CAUSE = 32'd11,
  parameter logic [31:0] IRQ_CAUSE   = 32'h8000000B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ecall_req,
  input  logic        mret_req,
  input  logic        irq_req,
  input  logic [31:0] pc,
  input  logic [31:0] mstatus_in,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    IDLE,
    W_EPC,
    W_CAUSE,
    W_STATUS,
    REDIRECT
  } state_t;

  state_t      state;
  logic        kind;      // 0 = trap entry, 1 = mret
  logic [31:0] epc_r;
  logic [31:0] cause_r;
  logic [31:0] status_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      kind    <= 1'b0;
      epc_r   <= '0;
      cause_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ecall_req) begin
            kind    <= 1'b0;
            epc_r   <= pc;
            cause_r <= ECALL_CAUSE;
            state   <= W_EPC;
          end else if (mret_req) begin
            kind  <= 1'b1;
            state <= W_STATUS;
          end else if (irq_req && mstatus_in[3]) begin
            kind    <= 1'b0;
            epc_r   <= pc;
            cause_r <= IRQ_CAUSE;
            state   <= W_EPC;
          end
        end
        W_EPC:    state <= W_CAUSE;
        W_CAUSE:  state <= W_STATUS;
        W_STATUS: state <= REDIRECT;
        REDIRECT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // mstatus rewrite uses the live CSR value so it reflects any earlier write commits
  always_comb begin
    status_next           = mstatus_in;
    status_next[12:11]    = 2'b11;
    if (kind) begin
      status_next[3] = mstatus_in[7];
      status_next[7] = 1'b1;
    end else begin
      status_next[7] = mstatus_in[3];
      status_next[3] = 1'b0;
    end
  end

  always_comb begin
    csr_we         = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    busy           = (state != IDLE);
    case (state)
      W_EPC: begin
        csr_we    = 1'b1;
        csr_waddr = ADDR_MEPC;
        csr_wdata = epc_r;
      end
      W_CAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = ADDR_MCAUSE;
        csr_wdata = cause_r;
      end
      W_STATUS: begin
        csr_we    = 1'b1;
        csr_waddr = ADDR_MSTATUS;
        csr_wdata = status_next;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = kind ? mepc_in : (mtvec_in & 32'hFFFF_FFFC);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - directed self-checking bench for trap_sequencer
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ecall_req, mret_req, irq_req;
  logic [31:0] pc, mstatus_in, mtvec_in, mepc_in;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        busy, redirect_valid;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int epc_cyc0, epc_cyc1;

  trap_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ecall_req      (ecall_req),
    .mret_req       (mret_req),
    .irq_req        (irq_req),
    .pc             (pc),
    .mstatus_in     (mstatus_in),
    .mtvec_in       (mtvec_in),
    .mepc_in        (mepc_in),
    .csr_we         (csr_we),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .busy           (busy),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic exp_cycle(input string tag, input logic we, input logic [11:0] addr,
                           input logic [31:0] data, input logic bsy, input logic rv,
                           input logic [31:0] rpc);
    @(negedge clk);
    check({tag, ".we"},    {31'd0, csr_we},         {31'd0, we});
    check({tag, ".addr"},  {20'd0, csr_waddr},      {20'd0, addr});
    check({tag, ".data"},  csr_wdata,               data);
    check({tag, ".busy"},  {31'd0, busy},           {31'd0, bsy});
    check({tag, ".rv"},    {31'd0, redirect_valid}, {31'd0, rv});
    check({tag, ".rpc"},   redirect_pc,             rpc);
  endtask

  task automatic exp_idle(input string tag);
    exp_cycle(tag, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // Starts in the W_EPC cycle, ends at the REDIRECT cycle
  task automatic trap_seq(input string tag, input logic [31:0] epc, input logic [31:0] cause,
                          input logic [31:0] newst, input logic [31:0] tgt);
    exp_cycle({tag, ".epc"}, 1'b1, 12'h341, epc, 1'b1, 1'b0, 32'h0);
    ecall_req = 1'b0; mret_req = 1'b0; irq_req = 1'b0;
    exp_cycle({tag, ".cause"},  1'b1, 12'h342, cause, 1'b1, 1'b0, 32'h0);
    exp_cycle({tag, ".status"}, 1'b1, 12'h300, newst, 1'b1, 1'b0, 32'h0);
    exp_cycle({tag, ".redir"},  1'b0, 12'h000, 32'h0, 1'b1, 1'b1, tgt);
  endtask

  initial begin
    rst_n = 1'b0; ecall_req = 1'b0; mret_req = 1'b0; irq_req = 1'b0;
    pc = 32'h0; mstatus_in = 32'h0; mtvec_in = 32'h0; mepc_in = 32'h0;
    exp_idle("reset");
    rst_n = 1'b1;
    exp_idle("idle0");

    // ecall
    pc = 32'h80000010; mstatus_in = 32'h1808; mtvec_in = 32'h80001003; ecall_req = 1'b1;
    trap_seq("ecall", 32'h80000010, 32'h0000000B, 32'h1880, 32'h80001000);
    exp_idle("ecall.done");

    // mret
    mstatus_in = 32'h1880; mepc_in = 32'h80000014; mret_req = 1'b1;
    exp_cycle("mret.status", 1'b1, 12'h300, 32'h1888, 1'b1, 1'b0, 32'h0);
    mret_req = 1'b0;
    exp_cycle("mret.redir", 1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 32'h80000014);
    exp_idle("mret.done");

    // irq masked, then enabled
    mstatus_in = 32'h1800; irq_req = 1'b1; pc = 32'h80000020;
    exp_idle("irq.masked0");
    exp_idle("irq.masked1");
    exp_idle("irq.masked2");
    mstatus_in = 32'h1808;
    trap_seq("irq", 32'h80000020, 32'h8000000B, 32'h1880, 32'h80001000);
    exp_idle("irq.done");

    // simultaneous requests, then mret during W_CAUSE
    pc = 32'h80000030; ecall_req = 1'b1; mret_req = 1'b1; irq_req = 1'b1;
    exp_cycle("prio.epc", 1'b1, 12'h341, 32'h80000030, 1'b1, 1'b0, 32'h0);
    ecall_req = 1'b0; mret_req = 1'b0; irq_req = 1'b0;
    exp_cycle("prio.cause", 1'b1, 12'h342, 32'h0000000B, 1'b1, 1'b0, 32'h0);
    mret_req = 1'b1;
    exp_cycle("prio.status", 1'b1, 12'h300, 32'h1880, 1'b1, 1'b0, 32'h0);
    mret_req = 1'b0;
    exp_cycle("prio.redir", 1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 32'h80001000);
    exp_idle("prio.done0");
    exp_idle("prio.done1");

    // reset during W_CAUSE
    pc = 32'h80000040; ecall_req = 1'b1;
    exp_cycle("rstmid.epc", 1'b1, 12'h341, 32'h80000040, 1'b1, 1'b0, 32'h0);
    ecall_req = 1'b0;
    exp_cycle("rstmid.cause", 1'b1, 12'h342, 32'h0000000B, 1'b1, 1'b0, 32'h0);
    rst_n = 1'b0;
    exp_idle("rstmid.abort");
    rst_n = 1'b1;
    exp_idle("rstmid.quiet");
    pc = 32'h80000050; ecall_req = 1'b1;
    trap_seq("after_rst", 32'h80000050, 32'h0000000B, 32'h1880, 32'h80001000);
    exp_idle("after_rst.done");

    // back-to-back ecalls on the first IDLE cycle
    pc = 32'h80000060; ecall_req = 1'b1;
    trap_seq("b2b0", 32'h80000060, 32'h0000000B, 32'h1880, 32'h80001000);
    epc_cyc0 = cyc - 3;
    pc = 32'h80000064; ecall_req = 1'b1;
    exp_idle("b2b.gap");
    trap_seq("b2b1", 32'h80000064, 32'h0000000B, 32'h1880, 32'h80001000);
    epc_cyc1 = cyc - 3;
    check("b2b.spacing", epc_cyc1 - epc_cyc0, 32'd5);
    exp_idle("b2b.done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
